// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: hex segment table,
// digit count and the active-low all-off pattern.
package seg7_pkg;

  localparam int DIGITS = 8;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Entry n (at bits 8n+7:8n) is the active-low pattern for hex digit n, dp off.
  localparam logic [16*8-1:0] HEX_SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    return HEX_SEG_TABLE[{nib, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble + decimal point to active-low {dp,g,f,e,d,c,b,a}.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] raw;

  always_comb begin
    raw = hex_seg(nibble);
    seg = {~dp, raw[6:0]};
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 8-digit seven-segment driver with per-frame word latching.
// Optional leading-zero blanking via macro SEG7_BLANK_LEADING_ZERO_EN.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [7:0]            dp_mask,
  output logic                  frame_done,
  output logic [7:0]            anodes,
  output logic [7:0]            cnodes
);

  localparam int SCAN_DEN = (SCAN_HZ > 0) ? SCAN_HZ : 1;
  localparam int DIV_RAW  = CLK_HZ / SCAN_DEN;
  localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0]      div_cnt;
  logic [2:0]            idx;
  logic [DATA_WIDTH-1:0] shadow;
  logic [7:0]            shadow_dp;
  logic                  primed;
  logic                  tick;
  logic                  wrap;
  logic                  load;
  logic [3:0]            nibble;
  logic [7:0]            seg;
  logic [7:0]            digit_seg;

  assign tick   = (DIV == 1) || (div_cnt == DIV_LAST);
  assign wrap   = primed && en && tick && (idx == 3'd7);
  assign load   = !primed || wrap;
  assign nibble = shadow[{idx, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble (nibble),
    .dp     (shadow_dp[idx]),
    .seg    (seg)
  );

`ifdef SEG7_BLANK_LEADING_ZERO_EN
  logic [2:0] lead;

  function automatic logic [2:0] lead_of(input logic [DATA_WIDTH-1:0] word);
    logic [2:0] k;
    k = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (word[4*i +: 4] != 4'd0) k = 3'(i);
    end
    return k;
  endfunction

  // Lead digit is captured alongside every shadow load so it matches the word shown.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lead <= 3'd0;
    end else if (load) begin
      lead <= lead_of(data);
    end
  end

  always_comb begin
    digit_seg = seg;
    if (idx > lead) digit_seg = shadow_dp[idx] ? 8'h7F : SEG_OFF;
  end
`else
  always_comb begin
    digit_seg = seg;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt    <= '0;
      idx        <= 3'd0;
      shadow     <= '0;
      shadow_dp  <= 8'h00;
      primed     <= 1'b0;
      anodes     <= SEG_OFF;
      cnodes     <= SEG_OFF;
      frame_done <= 1'b0;
    end else if (!primed) begin
      shadow     <= data;
      shadow_dp  <= dp_mask;
      primed     <= 1'b1;
      frame_done <= 1'b0;
    end else if (!en) begin
      // Frozen: digits dark, segment pins keep their last value.
      anodes     <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      anodes     <= ~(8'b1 << idx);
      cnodes     <= digit_seg;
      frame_done <= wrap;
      if (tick) begin
        div_cnt <= '0;
        idx     <= idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
      if (wrap) begin
        shadow    <= data;
        shadow_dp <= dp_mask;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: table vectors, hand-written corner sequences, random
// stimulus against a slot-count reference model, and a divider timing check.
module tb_seg7_scan;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, frame_done;
  logic [31:0] data;
  logic [7:0]  dp_mask, anodes, cnodes;

  logic        rst2, en2, frame_done2;
  logic [31:0] data2;
  logic [7:0]  dp_mask2, anodes2, cnodes2;

  seg7_scan #(.DATA_WIDTH(32), .CLK_HZ(0), .SCAN_HZ(1000)) dut (
    .clk(clk), .rst(rst), .en(en), .data(data), .dp_mask(dp_mask),
    .frame_done(frame_done), .anodes(anodes), .cnodes(cnodes)
  );

  seg7_scan #(.DATA_WIDTH(32), .CLK_HZ(8000), .SCAN_HZ(1000)) dut_div (
    .clk(clk), .rst(rst2), .en(en2), .data(data2), .dp_mask(dp_mask2),
    .frame_done(frame_done2), .anodes(anodes2), .cnodes(cnodes2)
  );

`ifdef SEG7_BLANK_LEADING_ZERO_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference model: a count of completed slots plus the word latched for the frame.
  bit          m_primed = 1'b0;
  int          m_pos    = 0;
  logic [31:0] m_word   = '0;
  logic [7:0]  m_dp     = '0;
  logic [7:0]  m_an     = 8'hFF;
  logic [7:0]  m_cn     = 8'hFF;
  logic        m_fd     = 1'b0;

  function automatic logic [7:0] hex_ref(input int n);
    case (n)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90; 10: return 8'h88; 11: return 8'h83;
      12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [7:0] ref_seg(input logic [31:0] w, input logic [7:0] dpm, input int d);
    int lead;
    int n;
    logic [7:0] hv;
    lead = 0;
    for (int k = 0; k < 8; k++) if (((w >> (4 * k)) & 32'hF) != 0) lead = k;
    if (LZ && d > lead) return dpm[d] ? 8'h7F : 8'hFF;
    n  = int'((w >> (4 * d)) & 32'hF);
    hv = hex_ref(n);
    return {~dpm[d], hv[6:0]};
  endfunction

  task automatic model_edge();
    int d;
    if (!rst) begin
      m_primed = 1'b0; m_pos = 0; m_word = '0; m_dp = '0;
      m_an = 8'hFF; m_cn = 8'hFF; m_fd = 1'b0;
    end else if (!m_primed) begin
      m_word = data; m_dp = dp_mask; m_primed = 1'b1; m_fd = 1'b0;
    end else if (!en) begin
      m_an = 8'hFF; m_fd = 1'b0;
    end else begin
      d    = m_pos % 8;
      m_an = ~(8'h01 << d);
      m_cn = ref_seg(m_word, m_dp, d);
      m_fd = (d == 7);
      if (d == 7) begin
        m_word = data;
        m_dp   = dp_mask;
      end
      m_pos++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check8("model_anodes", anodes, m_an);
    check8("model_cnodes", cnodes, m_cn);
    check8("model_frame_done", {7'b0, frame_done}, {7'b0, m_fd});
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] data;
    logic [7:0]  an;
    logic [7:0]  cn;
    logic        fd;
  } vec_t;

  vec_t tv[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tear_exp[5];
    logic [7:0] prev;
    int run, fds, first_fd, last_fd;

    rst = 1'b0; en = 1'b1; data = 32'h12345678; dp_mask = 8'h00;
    rst2 = 1'b0; en2 = 1'b1; data2 = 32'h0123ABCD; dp_mask2 = 8'h00;

    tv[0]  = '{1'b0, 32'h12345678, 8'hFF, 8'hFF, 1'b0};
    tv[1]  = '{1'b0, 32'h12345678, 8'hFF, 8'hFF, 1'b0};
    tv[2]  = '{1'b0, 32'h12345678, 8'hFF, 8'hFF, 1'b0};
    tv[3]  = '{1'b1, 32'h0123ABCD, 8'hFF, 8'hFF, 1'b0};
    tv[4]  = '{1'b1, 32'h0123ABCD, 8'hFE, 8'hA1, 1'b0};
    tv[5]  = '{1'b1, 32'h0123ABCD, 8'hFD, 8'hC6, 1'b0};
    tv[6]  = '{1'b1, 32'h0123ABCD, 8'hFB, 8'h83, 1'b0};
    tv[7]  = '{1'b1, 32'h0123ABCD, 8'hF7, 8'h88, 1'b0};
    tv[8]  = '{1'b1, 32'h0123ABCD, 8'hEF, 8'hB0, 1'b0};
    tv[9]  = '{1'b1, 32'h0123ABCD, 8'hDF, 8'hA4, 1'b0};
    tv[10] = '{1'b1, 32'h0123ABCD, 8'hBF, 8'hF9, 1'b0};
    tv[11] = '{1'b1, 32'h0123ABCD, 8'h7F, (LZ ? 8'hFF : 8'hC0), 1'b1};
    tv[12] = '{1'b1, 32'h0123ABCD, 8'hFE, 8'hA1, 1'b0};

    for (int i = 0; i < 13; i++) begin
      rst  = tv[i].rst;
      data = tv[i].data;
      step();
      check8($sformatf("vec%0d_anodes", i), anodes, tv[i].an);
      check8($sformatf("vec%0d_cnodes", i), cnodes, tv[i].cn);
      check8($sformatf("vec%0d_frame_done", i), {7'b0, frame_done}, {7'b0, tv[i].fd});
    end

    // Tearing: new word arrives mid-frame and must wait for the wrap.
    for (int i = 0; i < 16 && (m_pos % 8) != 3; i++) step();
    data = 32'hFFFFFFFF;
    tear_exp = '{8'h88, 8'hB0, 8'hA4, 8'hF9, (LZ ? 8'hFF : 8'hC0)};
    for (int i = 0; i < 5; i++) begin
      step();
      check8($sformatf("tear_old_digit%0d", i + 3), cnodes, tear_exp[i]);
    end
    check8("tear_wrap_frame_done", {7'b0, frame_done}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      step();
      check8($sformatf("tear_new_digit%0d", i), cnodes, 8'h8E);
    end

    // Enable freeze at slot 5, then resume from the same slot.
    for (int i = 0; i < 16 && (m_pos % 8) != 5; i++) step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check8("en_off_anodes", anodes, 8'hFF);
      check8("en_off_frame_done", {7'b0, frame_done}, 8'h00);
    end
    en = 1'b1;
    step();
    check8("en_resume_anodes", anodes, 8'hDF);

    // Decimal point on digit 2, latched at the next wrap.
    dp_mask = 8'h04;
    for (int i = 0; i < 16 && (m_pos % 8) != 0; i++) step();
    step();
    step();
    check8("dp_digit1_off", cnodes, 8'h8E);
    step();
    check8("dp_digit2_anodes", anodes, 8'hFB);
    check8("dp_digit2_on", cnodes, 8'h0E);

    // Leading-zero handling after a mid-frame reset and fresh prime.
    dp_mask = 8'h00;
    rst = 1'b0;
    step();
    rst = 1'b1; data = 32'h000000A0;
    step();
    data = 32'h00000000;
    for (int d = 0; d < 8; d++) begin
      step();
      check8($sformatf("lz_a0_digit%0d", d), cnodes,
             (d == 0) ? 8'hC0 : (d == 1) ? 8'h88 : (LZ ? 8'hFF : 8'hC0));
    end
    step();
    check8("lz_zero_digit0", cnodes, 8'hC0);
    step();
    check8("lz_zero_digit1", cnodes, LZ ? 8'hFF : 8'hC0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 49) != 0);
      en      = ($urandom_range(0, 5) != 0);
      data    = $urandom >> (4 * $urandom_range(0, 8));
      dp_mask = 8'($urandom);
      step();
    end

    // Divider: DIV=8 gives 8-cycle slots and a 64-cycle frame.
    @(posedge clk);
    #1;
    rst2 = 1'b1;
    prev = anodes2; run = 0; fds = 0; first_fd = -1; last_fd = -1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (anodes2 !== prev) begin
        if (prev !== 8'hFF) check_int("div_slot_len", run, 8);
        prev = anodes2;
        run  = 1;
      end else begin
        run++;
      end
      if (frame_done2) begin
        if (last_fd >= 0) check_int("div_frame_period", c - last_fd, 64);
        else first_fd = c;
        last_fd = c;
        fds++;
      end
    end
    check_int("div_first_frame_done", first_fd, 64);
    check_int("div_frame_count", fds, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
